mac_sequencer: RTL

Dot-product controller driving the 8-bit multiply-accumulate unit from the operand-producer side. On `start` it reads `len` operand pairs from a synchronous-read operand buffer, clears the MAC, streams the pairs into it one per cycle with `enable`, waits for the final accumulate to settle, and presents the 24-bit sum on a valid/ready result port. It sits between the layer controller and one `mac` instance.

---
 rtl/mac_sequencer_if.sv | 47 ++++
 rtl/mac_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: bundles the request, operand buffer, MAC and result signals
// of one mac_sequencer.
//   slave  : sequencer view (drives busy, rd_*, mac_clear/enable/a/b, res_valid/data)
//   master : environment view (drives start, len, bias, rd_a/b, mac_out, res_ready)
// Optional MAC_SEQ_BIAS_EN adds the bias request field.
interface mac_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
);
    logic              start;
    logic [LEN_W-1:0]  len;
`ifdef MAC_SEQ_BIAS_EN
    logic [ACC_W-1:0]  bias;
`endif
    logic              busy;
    logic              rd_en;
    logic [LEN_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              mac_clear;
    logic              mac_enable;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [ACC_W-1:0]  mac_out;
    logic              res_valid;
    logic [ACC_W-1:0]  res_data;
    logic              res_ready;

    modport slave (
`ifdef MAC_SEQ_BIAS_EN
        input  bias,
`endif
        input  start, len, rd_a, rd_b, mac_out, res_ready,
        output busy, rd_en, rd_addr, mac_clear, mac_enable, mac_a, mac_b,
               res_valid, res_data
    );

    modport master (
`ifdef MAC_SEQ_BIAS_EN
        output bias,
`endif
        output start, len, rd_a, rd_b, mac_out, res_ready,
        input  busy, rd_en, rd_addr, mac_clear, mac_enable, mac_a, mac_b,
               res_valid, res_data
    );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: dot-product controller feeding one 8-bit MAC from an operand buffer.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears all state and outputs
//   bus   : mac_sequencer_if.slave (start/len request, buffer read port,
//           MAC control/operands, valid/ready result port)
// Optional MAC_SEQ_BIAS_EN: latches bus.bias with start and adds it to the result.
module mac_sequencer #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input logic            clk,
    input logic            reset,
    mac_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rd_addr_q, rd_addr_d;
    logic              busy_q, busy_d;
    logic              rd_en_q, rd_en_d;
    logic              en1_q, en1_d;
    logic              mac_clear_q, mac_clear_d;
    logic              mac_enable_q, mac_enable_d;
    logic [DATA_W-1:0] mac_a_q, mac_a_d;
    logic [DATA_W-1:0] mac_b_q, mac_b_d;
    logic              res_valid_q, res_valid_d;
    logic [ACC_W-1:0]  res_data_q, res_data_d;
    logic [ACC_W-1:0]  bias_q;
`ifdef MAC_SEQ_BIAS_EN
    logic [ACC_W-1:0]  bias_d;
`else
    assign bias_q = '0;
`endif
    logic              last;

    assign last = rd_addr_q == len_q - LEN_W'(1);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        rd_addr_d    = rd_addr_q;
        rd_en_d      = 1'b0;
        mac_clear_d  = 1'b0;
        // en1 marks the cycle buffer data is valid; mac_enable follows one cycle later
        en1_d        = rd_en_q;
        mac_enable_d = en1_q;
        mac_a_d      = en1_q ? bus.rd_a : mac_a_q;
        mac_b_d      = en1_q ? bus.rd_b : mac_b_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
`ifdef MAC_SEQ_BIAS_EN
        bias_d       = bias_q;
`endif
        case (state_q)
            IDLE: if (bus.start) begin
                state_d     = CLEAR;
                len_d       = bus.len;
`ifdef MAC_SEQ_BIAS_EN
                bias_d      = bus.bias;
`endif
                mac_clear_d = 1'b1;
                rd_en_d     = bus.len != '0;
                rd_addr_d   = '0;
            end
            // rd_addr_q holds the address issued this cycle (0 in CLEAR)
            CLEAR, FETCH: begin
                if (len_q == '0) begin
                    state_d    = DONE;
                    res_data_d = bias_q;
                end else if (last) begin
                    state_d = DRAIN;
                end else begin
                    state_d   = FETCH;
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + LEN_W'(1);
                end
            end
            // once the read pipeline is empty the last accumulate has settled in mac_out
            DRAIN: if (!(rd_en_q || en1_q || mac_enable_q)) begin
                state_d     = DONE;
                res_data_d  = bus.mac_out + bias_q;
                res_valid_d = 1'b1;
            end
            DONE: begin
                state_d     = (res_valid_q && bus.res_ready) ? IDLE : DONE;
                res_valid_d = !(res_valid_q && bus.res_ready);
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            rd_addr_q    <= '0;
            busy_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            en1_q        <= 1'b0;
            mac_clear_q  <= 1'b0;
            mac_enable_q <= 1'b0;
            mac_a_q      <= '0;
            mac_b_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
`ifdef MAC_SEQ_BIAS_EN
            bias_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rd_addr_q    <= rd_addr_d;
            busy_q       <= busy_d;
            rd_en_q      <= rd_en_d;
            en1_q        <= en1_d;
            mac_clear_q  <= mac_clear_d;
            mac_enable_q <= mac_enable_d;
            mac_a_q      <= mac_a_d;
            mac_b_q      <= mac_b_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
`ifdef MAC_SEQ_BIAS_EN
            bias_q       <= bias_d;
`endif
        end
    end

    assign bus.busy       = busy_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.mac_clear  = mac_clear_q;
    assign bus.mac_enable = mac_enable_q;
    assign bus.mac_a      = mac_a_q;
    assign bus.mac_b      = mac_b_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
endmodule
